// File: rtl/sort_rank_sequencer_pkg.sv
// sort_pkg: shared types and constants for the rank sequencer and its sorting network.
package sort_pkg;
   localparam int MAX_NUM_SIZE = 32;
   localparam logic [MAX_NUM_SIZE-1:0] SORT_SENTINEL = '1;
   typedef enum logic {IDLE, EMIT} seq_state_t;
   typedef logic [1:0] rank_t;
endpackage

// File: rtl/sort_rank_sequencer_nth_smallest.sv
// nth_smallest: combinational 4-input selector returning the index_i-th smallest value (unsigned).
module nth_smallest
   import sort_pkg::*;
#(
   parameter int W = sort_pkg::MAX_NUM_SIZE
) (
   input  logic              valid_i,
   input  logic [3:0][W-1:0] numbers_i,
   input  rank_t             index_i,
   output logic [W-1:0]      value_o
);
   rank_t pos;
   // Equal values are ranked by position, so every value gets a unique rank.
   always_comb begin
      value_o = '0;
      pos     = '0;
      for (int i = 0; i < 4; i++) begin
         pos = '0;
         for (int j = 0; j < 4; j++)
            pos = pos + rank_t'((j != i) && ((numbers_i[j] < numbers_i[i]) || ((numbers_i[j] == numbers_i[i]) && (j < i))));
         if (valid_i && (pos == index_i)) value_o = numbers_i[i];
      end
   end
endmodule

// File: rtl/sort_rank_sequencer.sv
// sort_rank_sequencer: latches a batch of four values and emits the k+1 smallest, ascending, one per beat.
// Define SORT_SKIP_SENTINEL_EN to drop all-ones "no hit" values from the output.
module sort_rank_sequencer
   import sort_pkg::*;
#(
   parameter int MAX_NUM_SIZE = sort_pkg::MAX_NUM_SIZE
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [3:0][MAX_NUM_SIZE-1:0] numbers_in,
   input  logic [1:0]                   k_in,
   input  logic                         valid_in,
   output logic                         ready_out,
   output logic [MAX_NUM_SIZE-1:0]      data_out,
   output logic [1:0]                   rank_out,
   output logic                         last_out,
   output logic                         valid_out,
   input  logic                         ready_in,
   output logic                         busy_out
);
   seq_state_t                   state_q, state_d;
   rank_t                        rank_q, rank_d, k_q, k_d, k_eff;
   logic [3:0][MAX_NUM_SIZE-1:0] nums_q, nums_d;
   logic                         init_q, go;
`ifdef SORT_SKIP_SENTINEL_EN
   logic [2:0] cnt;
   // Sentinels sort to the top, so the first cnt ranks are exactly the real hits.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < 4; i++) cnt = cnt + {2'b0, ~&numbers_in[i]};
      go    = cnt != 3'd0;
      k_eff = !go ? '0 : ({1'b0, k_in} < cnt) ? k_in : rank_t'(cnt - 3'd1);
   end
`else
   assign go    = 1'b1;
   assign k_eff = k_in;
`endif
   assign ready_out = init_q && (state_q == IDLE);
   assign valid_out = state_q == EMIT;
   assign busy_out  = state_q == EMIT;
   assign rank_out  = rank_q;
   assign last_out  = valid_out && (rank_q == k_q);
   nth_smallest #(.W(MAX_NUM_SIZE)) u_sort (
      .valid_i   (state_q == EMIT),
      .numbers_i (nums_q),
      .index_i   (rank_q),
      .value_o   (data_out)
   );
   always_comb begin
      state_d = state_q;
      rank_d  = rank_q;
      nums_d  = nums_q;
      k_d     = k_q;
      if (valid_in && ready_out) begin
         nums_d  = numbers_in;
         k_d     = k_eff;
         rank_d  = '0;
         state_d = go ? EMIT : IDLE;
      end
      if (valid_out && ready_in) begin
         rank_d  = last_out ? '0 : rank_q + 2'd1;
         state_d = last_out ? IDLE : EMIT;
      end
   end
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         rank_q  <= '0;
         nums_q  <= '0;
         k_q     <= '0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rank_q  <= rank_d;
         nums_q  <= nums_d;
         k_q     <= k_d;
         init_q  <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sort_rank_sequencer.sv
// tb_sort_rank_sequencer: directed self-checking bench for sort_rank_sequencer.
module tb_sort_rank_sequencer;
   logic              clk_in = 0, rst_in = 1;
   logic [3:0][31:0]  numbers_in = '0;
   logic [1:0]        k_in = '0;
   logic              valid_in = 0, ready_in = 1;
   logic              ready_out, last_out, valid_out, busy_out;
   logic [31:0]       data_out;
   logic [1:0]        rank_out;
   int                n_chk = 0, n_pass = 0, cyc = 0;
   sort_rank_sequencer dut (
      .clk_in(clk_in), .rst_in(rst_in), .numbers_in(numbers_in), .k_in(k_in),
      .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out), .rank_out(rank_out),
      .last_out(last_out), .valid_out(valid_out), .ready_in(ready_in), .busy_out(busy_out)
   );
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // Entered and left at a negedge with the sequencer idle; exp[0] is the smallest expected beat.
   task automatic run_batch(input logic [3:0][31:0] nums, input logic [1:0] k,
                            input logic [3:0][31:0] exp, input int n);
      int c0;
      numbers_in = nums; k_in = k; valid_in = 1;
      chk("rdy_pre", ready_out, 1);
      c0 = cyc;
      @(negedge clk_in);
      valid_in = 0;
      for (int r = 0; r < n; r++) begin
         chk("valid", valid_out, 1);
         chk("data", data_out, exp[r]);
         chk("rank", rank_out, r);
         chk("last", last_out, r == n - 1);
         chk("rdy_busy", {ready_out, busy_out}, 2'b01);
         @(negedge clk_in);
      end
      chk("idle_valid", valid_out, 0);
      chk("idle_rdy", ready_out, 1);
      chk("cycles", cyc - c0, n + 1);
   endtask
   initial begin
      logic [3:0][31:0] v, s;
      logic [31:0] t;
      int e, kk;
      logic p;
      #2;
      chk("rst_valid", valid_out, 0);
      chk("rst_rdy", ready_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_busy", busy_out, 0);
      @(negedge clk_in); rst_in = 0;
      #1 chk("rdy_before_edge", ready_out, 0);
      @(negedge clk_in);
      chk("rdy_after_edge", ready_out, 1);
      // 1: full batch, consumer always ready
      run_batch({32'd7, 32'd3, 32'd9, 32'd1}, 2'd3, {32'd9, 32'd7, 32'd3, 32'd1}, 4);
      // 2: consumer stalls on a 1,0,0 pattern
      numbers_in = {32'd7, 32'd3, 32'd9, 32'd1}; k_in = 3; valid_in = 1;
      s = {32'd9, 32'd7, 32'd3, 32'd1};
      @(negedge clk_in); valid_in = 0;
      e = 0;
      for (int c = 0; c < 20 && e < 4; c++) begin
         p = (c % 3) == 0;
         ready_in = p;
         chk("stall_valid", valid_out, 1);
         chk("stall_data", data_out, s[e]);
         chk("stall_rank", rank_out, e);
         chk("stall_last", last_out, e == 3);
         @(negedge clk_in);
         if (p) e++;
      end
      chk("stall_count", e, 4);
      ready_in = 1;
      chk("stall_done", {valid_out, ready_out}, 2'b01);
      // 3: ties, and valid_in/new data during EMIT ignored
      numbers_in = {32'd5, 32'd5, 32'd2, 32'd5}; k_in = 1; valid_in = 1;
      @(negedge clk_in);
      numbers_in = '0; k_in = 3;
      chk("tie0", {valid_out, ready_out, last_out}, 3'b100);
      chk("tie0_data", data_out, 2);
      @(negedge clk_in);
      chk("tie1", {valid_out, rank_out, last_out}, 4'b1011);
      chk("tie1_data", data_out, 5);
      valid_in = 0;
      @(negedge clk_in);
      chk("tie_idle", {valid_out, ready_out}, 2'b01);
      @(negedge clk_in);
      chk("tie_noreacc", valid_out, 0);
      // 4: reset mid-EMIT after rank 1
      numbers_in = {32'd7, 32'd3, 32'd9, 32'd1}; k_in = 3; valid_in = 1;
      @(negedge clk_in); valid_in = 0;
      @(negedge clk_in);
      chk("pre_rst_rank", rank_out, 1);
      #2 rst_in = 1;
      #1 chk("mid_rst", {valid_out, last_out, ready_out, busy_out}, 4'b0000);
      chk("mid_rst_data", data_out, 0);
      chk("mid_rst_rank", rank_out, 0);
      @(negedge clk_in); rst_in = 0;
      @(negedge clk_in);
      run_batch({32'd4, 32'd8, 32'd6, 32'd2}, 2'd2, {32'd0, 32'd6, 32'd4, 32'd2}, 3);
      // 5: sentinel handling
`ifdef SORT_SKIP_SENTINEL_EN
      run_batch({32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFF, 32'd2}, 2'd3, {64'd0, 32'd4, 32'd2}, 2);
      run_batch({4{32'hFFFF_FFFF}}, 2'd3, '0, 0);
      chk("sent_all_busy", busy_out, 0);
`else
      run_batch({32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFF, 32'd2}, 2'd3,
                {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'd2}, 4);
`endif
      // 6: back-to-back random batches against a sorting model
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < 4; i++) v[i] = (b < 3) ? 32'($urandom_range(0, 15)) : $urandom;
         kk = $urandom_range(0, 3);
         s = v;
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3 - i; j++)
               if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
         run_batch(v, 2'(kk), s, kk + 1);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
